// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the MEM-stage data port and the SRAM side of the
// unified-memory arbiter.
//
// Modports:
//   slave  - the arbiter: takes requests and sram_rdata, drives ready pulses,
//            read data, freeze and the SRAM address/data/strobes.
//   master - the surrounding pipeline and SRAM: drive requests and
//            sram_rdata, observe everything else.
//
// Signals:
//   if_req/if_addr            fetch request (level, held until if_ready)
//   if_ready/if_rdata         fetch completion pulse and instruction
//   mem_r_en/mem_w_en         load/store request (level, held until mem_ready)
//   mem_addr/mem_wdata        data address and store data
//   mem_ready/mem_rdata       data completion pulse and load data
//   freeze                    pipeline stall while a data access is pending
//   sram_addr/sram_wdata      registered SRAM address and write data
//   sram_we/sram_oe           SRAM write strobe and output enable
//   sram_rdata                SRAM read data
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              freeze;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_we;
    logic              sram_oe;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata,
               sram_rdata,
        output if_ready, if_rdata, mem_ready, mem_rdata, freeze,
               sram_addr, sram_wdata, sram_we, sram_oe
    );

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata,
               sram_rdata,
        input  if_ready, if_rdata, mem_ready, mem_rdata, freeze,
               sram_addr, sram_wdata, sram_we, sram_oe
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, fixed-latency SRAM between instruction fetch and
// the MEM stage. One transfer at a time: IDLE arbitrates and latches the
// request, ACCESS holds the SRAM strobes for WAIT_CYCLES cycles, RESP gives
// the granted port a one-cycle ready pulse, then back to IDLE.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_port_arbiter_if.slave (fetch port, data port, SRAM side)
//
// Parameters: ADDR_W, DATA_W, WAIT_CYCLES (1..15 SRAM cycles per transfer)
//
// Optional feature macro ARB_RR_EN: when defined, simultaneous requests are
// granted round-robin using a last_grant bit; when undefined the data port
// always wins.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_LOAD, GNT_STORE} grant_t;

    state_t            state;
    state_t            state_next;
    grant_t            grant;
    grant_t            grant_pick;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              if_ready;
    logic              mem_ready;
    logic              sram_we;
    logic              sram_oe;
    logic              mem_pend;
    logic              any_pend;
    logic              pick_mem;

    assign mem_pend = bus.mem_r_en | bus.mem_w_en;
    assign any_pend = mem_pend | bus.if_req;

`ifdef ARB_RR_EN
    // 1 = data port was granted last; reset value favours the data port first.
    logic last_grant;

    assign pick_mem = mem_pend & (~bus.if_req | ~last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b0;
        end else if (state == IDLE && any_pend) begin
            last_grant <= pick_mem;
        end
    end
`else
    // The MEM-stage instruction is older than the one being fetched.
    assign pick_mem = mem_pend;
`endif

    // A simultaneous load+store request is treated as a store.
    assign grant_pick = pick_mem ? (bus.mem_w_en ? GNT_STORE : GNT_LOAD) : GNT_FETCH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if_ready   = 1'b0;
        mem_ready  = 1'b0;
        sram_we    = 1'b0;
        sram_oe    = 1'b0;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                sram_we = (grant == GNT_STORE);
                sram_oe = (grant == GNT_FETCH) || (grant == GNT_LOAD);
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                // Requester still holds its request here, so never re-arbitrate.
                if_ready   = (grant == GNT_FETCH);
                mem_ready  = (grant == GNT_LOAD) || (grant == GNT_STORE);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= GNT_NONE;
            cnt        <= 4'd0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        grant     <= grant_pick;
                        cnt       <= CNT_INIT;
                        sram_addr <= pick_mem ? bus.mem_addr : bus.if_addr;
                        if (grant_pick == GNT_STORE) begin
                            sram_wdata <= bus.mem_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (grant == GNT_FETCH) begin
                        if_rdata <= bus.sram_rdata;
                    end else if (grant == GNT_LOAD) begin
                        mem_rdata <= bus.sram_rdata;
                    end
                end
                RESP: begin
                    grant <= GNT_NONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.if_ready   = if_ready;
    assign bus.mem_ready  = mem_ready;
    assign bus.if_rdata   = if_rdata;
    assign bus.mem_rdata  = mem_rdata;
    assign bus.sram_addr  = sram_addr;
    assign bus.sram_wdata = sram_wdata;
    assign bus.sram_we    = sram_we;
    assign bus.sram_oe    = sram_oe;
    assign bus.freeze     = mem_pend & ~mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// corner sequences (reset, priority, mid-access reset, WAIT_CYCLES=1) and a
// randomized run against a transaction-level reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int W  = 2;
    localparam int NR = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // SRAM behind the main DUT: 256 words, combinational read, write on edge.
    logic [31:0] sram_mem [256];
    logic [31:0] ref_mem  [256];

    function automatic logic [31:0] pat(input int i);
        if (i == 16) return 32'hE3A01005;
        return 32'hA5A50000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= pat(i);
        end else if (bus.sram_we) begin
            sram_mem[bus.sram_addr[9:2]] <= bus.sram_wdata;
        end
    end
    assign bus.sram_rdata  = bus.sram_oe  ? sram_mem[bus.sram_addr[9:2]] : 32'h0;
    assign bus1.sram_rdata = bus1.sram_oe ? ~bus1.sram_addr : 32'h0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic clear_inputs();
        bus.if_req = 1'b0;  bus.if_addr = '0;
        bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        bus1.mem_r_en = 1'b0; bus1.mem_w_en = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; mem_init = 1'b1;
        clear_inputs();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; mem_init = 1'b0;
    endtask

    typedef struct {
        int          port;      // 0 fetch, 1 load, 2 store, 3 load+store
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata; // port rdata expected in the ready cycle
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input int idx);
        int rdy_at = -1, we_n = 0, oe_n = 0;
        bit frz_ok = 1'b1, other_rdy = 1'b0, is_wr;
        logic [31:0] got = '0;
        is_wr = (v.port >= 2);
        @(posedge clk); #1;
        case (v.port)
            0: begin bus.if_req = 1'b1; bus.if_addr = v.addr; end
            1: begin bus.mem_r_en = 1'b1; bus.mem_addr = v.addr; end
            2: begin bus.mem_w_en = 1'b1; bus.mem_addr = v.addr; bus.mem_wdata = v.wdata; end
            default: begin
                bus.mem_r_en = 1'b1; bus.mem_w_en = 1'b1;
                bus.mem_addr = v.addr; bus.mem_wdata = v.wdata;
            end
        endcase
        for (int k = 0; k < W + 4 && rdy_at < 0; k++) begin
            @(negedge clk);
            if (bus.sram_we) we_n++;
            if (bus.sram_oe) oe_n++;
            if (v.port == 0) begin
                if (bus.mem_ready) other_rdy = 1'b1;
                if (bus.if_ready) begin rdy_at = k; got = bus.if_rdata; end
            end else begin
                if (bus.if_ready) other_rdy = 1'b1;
                if (bus.freeze !== ~bus.mem_ready) frz_ok = 1'b0;
                if (bus.mem_ready) begin rdy_at = k; got = bus.mem_rdata; end
            end
        end
        @(posedge clk); #1;
        bus.if_req = 1'b0; bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d_latency", idx), 32'(rdy_at), 32'(W + 1));
        chk($sformatf("vec%0d_rdata", idx), got, v.exp_rdata);
        chk($sformatf("vec%0d_we_cycles", idx), 32'(we_n), is_wr ? 32'(W) : 32'd0);
        chk($sformatf("vec%0d_oe_cycles", idx), 32'(oe_n), is_wr ? 32'd0 : 32'(W));
        chk($sformatf("vec%0d_other_ready", idx), 32'(other_rdy), 32'd0);
        if (v.port != 0) chk($sformatf("vec%0d_freeze", idx), 32'(frz_ok), 32'd1);
        chk($sformatf("vec%0d_freeze_after", idx), 32'(bus.freeze), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int mem_at, if_at, n_rdy;
        bit both_hi, any_rdy;
        logic [2:0] order;
        clear_inputs();

        // ---- reset, then 5 idle cycles ----
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_strobes", {28'd0, bus.if_ready, bus.mem_ready, bus.sram_we, bus.sram_oe}, 32'd0);
            chk("idle_freeze", 32'(bus.freeze), 32'd0);
        end
        chk("rst_sram_addr", bus.sram_addr, 32'd0);
        chk("rst_sram_wdata", bus.sram_wdata, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);

        // ---- directed vector table ----
        vecs[0] = '{port: 0, addr: 32'h40,  wdata: 32'h0,        exp_rdata: 32'hE3A01005};
        vecs[1] = '{port: 2, addr: 32'h100, wdata: 32'hDEADBEEF, exp_rdata: 32'h00000000};
        vecs[2] = '{port: 1, addr: 32'h100, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
        vecs[3] = '{port: 3, addr: 32'h104, wdata: 32'h12345678, exp_rdata: 32'hDEADBEEF};
        vecs[4] = '{port: 1, addr: 32'h104, wdata: 32'h0,        exp_rdata: 32'h12345678};
        vecs[5] = '{port: 0, addr: 32'h100, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
        vecs[6] = '{port: 1, addr: 32'h3FC, wdata: 32'h0,        exp_rdata: 32'hA5A500FF};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // ---- simultaneous fetch + load: data first, fetch after ----
        do_reset();
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.mem_r_en = 1'b1; bus.mem_addr = 32'h100;
        mem_at = -1; if_at = -1; both_hi = 1'b0;
        for (int k = 0; k < 3 * W + 8 && (mem_at < 0 || if_at < 0); k++) begin
            @(negedge clk);
            if (bus.mem_ready && bus.if_ready) both_hi = 1'b1;
            if (bus.mem_ready && mem_at < 0) mem_at = k;
            if (bus.if_ready && if_at < 0) if_at = k;
            @(posedge clk); #1;
            if (mem_at >= 0) bus.mem_r_en = 1'b0;
            if (if_at >= 0) bus.if_req = 1'b0;
        end
        clear_inputs();
        chk("prio_mem_ready_cycle", 32'(mem_at), 32'(W + 1));
        chk("prio_if_ready_cycle", 32'(if_at), 32'(2 * W + 3));
        chk("prio_both_ready", 32'(both_hi), 32'd0);

        // ---- both held across back-to-back transfers ----
        do_reset();
        @(posedge clk); #1;
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.mem_r_en = 1'b1; bus.mem_addr = 32'h100;
        n_rdy = 0; order = '0;
        for (int k = 0; k < 3 * (W + 2) + 2 && n_rdy < 3; k++) begin
            @(negedge clk);
            if (bus.mem_ready || bus.if_ready) begin
                order[n_rdy] = bus.mem_ready;
                n_rdy++;
            end
            @(posedge clk); #1;
        end
        clear_inputs();
        chk("held_transfers", 32'(n_rdy), 32'd3);
`ifdef ARB_RR_EN
        chk("held_grant_order", 32'(order), 32'b101);
`else
        chk("held_grant_order", 32'(order), 32'b111);
`endif

        // ---- reset during ACCESS aborts the store ----
        @(posedge clk); #1;
        bus.mem_w_en = 1'b1; bus.mem_addr = 32'h108; bus.mem_wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        chk("abort_we_before", 32'(bus.sram_we), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_strobes_after", {30'd0, bus.sram_we, bus.sram_oe}, 32'd0);
        any_rdy = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            if (bus.mem_ready || bus.if_ready) any_rdy = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_ready", 32'(any_rdy), 32'd0);

        // ---- WAIT_CYCLES=1 instance ----
        @(posedge clk); #1;
        bus1.if_req = 1'b1; bus1.if_addr = 32'h80;
        if_at = -1;
        for (int k = 0; k < 6 && if_at < 0; k++) begin
            @(negedge clk);
            if (bus1.if_ready) begin if_at = k; chk("w1_rdata", bus1.if_rdata, ~32'h80); end
        end
        chk("w1_ready_cycle", 32'(if_at), 32'd2);
        @(posedge clk); #1;
        bus1.if_req = 1'b0;
        @(posedge clk); #1;
        bus1.if_req = 1'b1; bus1.if_addr = 32'h84;
        @(posedge clk); #1;
        bus1.if_req = 1'b0;   // dropped while in ACCESS
        if_at = -1; n_rdy = 0; any_rdy = 1'b0;
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            if (bus1.if_ready) begin
                n_rdy++;
                if (if_at < 0) begin if_at = k; chk("w1_drop_rdata", bus1.if_rdata, ~32'h84); end
            end
            if (k > 2 && (bus1.sram_oe || bus1.mem_ready)) any_rdy = 1'b1;
            @(posedge clk); #1;
        end
        chk("w1_drop_ready_cycle", 32'(if_at), 32'd2);
        chk("w1_drop_pulses", 32'(n_rdy), 32'd1);
        chk("w1_drop_no_retry", 32'(any_rdy), 32'd0);

        // ---- randomized run against the transaction model ----
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        begin
            int free_at = 0, rsp_at = -100;
            bit rsp_fetch = 1'b0, rsp_write = 1'b0, pick_mem, mem_p;
            bit if_done = 1'b0, mem_done = 1'b0, e_if, e_mem, in_acc;
            bit last_mem = 1'b0;
            logic [31:0] rsp_addr = '0, rsp_data = '0;
            logic [31:0] exp_if_rdata = '0, exp_mem_rdata = '0;
            int kind;
            for (int c = 0; c < NR; c++) begin
                @(posedge clk); #1;
                if (if_done) bus.if_req = 1'b0;
                if (mem_done) begin bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0; end
                if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                    bus.if_req = 1'b1;
                    bus.if_addr = 32'($urandom_range(0, 31)) << 2;
                end
                if (!(bus.mem_r_en || bus.mem_w_en) && $urandom_range(0, 2) == 0) begin
                    kind = int'($urandom_range(0, 3));
                    bus.mem_r_en = (kind != 1);
                    bus.mem_w_en = (kind == 1) || (kind == 2);
                    bus.mem_addr = 32'($urandom_range(0, 31)) << 2;
                    bus.mem_wdata = $urandom;
                end
                @(negedge clk);
                mem_p = bus.mem_r_en || bus.mem_w_en;
                if (c >= free_at && (bus.if_req || mem_p)) begin
                    pick_mem = mem_p;
`ifdef ARB_RR_EN
                    if (mem_p && bus.if_req) pick_mem = !last_mem;
`endif
                    last_mem  = pick_mem;
                    rsp_fetch = !pick_mem;
                    rsp_write = pick_mem && bus.mem_w_en;
                    rsp_addr  = pick_mem ? bus.mem_addr : bus.if_addr;
                    rsp_at    = c + W + 1;
                    free_at   = c + W + 2;
                    if (rsp_write) ref_mem[rsp_addr[9:2]] = bus.mem_wdata;
                    else rsp_data = ref_mem[rsp_addr[9:2]];
                end
                e_if   = (c == rsp_at) && rsp_fetch;
                e_mem  = (c == rsp_at) && !rsp_fetch;
                in_acc = (c >= rsp_at - W) && (c < rsp_at);
                if (e_if) exp_if_rdata = rsp_data;
                if (e_mem && !rsp_write) exp_mem_rdata = rsp_data;
                chk("rnd_if_ready", 32'(bus.if_ready), 32'(e_if));
                chk("rnd_mem_ready", 32'(bus.mem_ready), 32'(e_mem));
                chk("rnd_if_rdata", bus.if_rdata, exp_if_rdata);
                chk("rnd_mem_rdata", bus.mem_rdata, exp_mem_rdata);
                chk("rnd_freeze", 32'(bus.freeze), 32'(mem_p && !e_mem));
                chk("rnd_sram_we", 32'(bus.sram_we), 32'(in_acc && rsp_write));
                chk("rnd_sram_oe", 32'(bus.sram_oe), 32'(in_acc && !rsp_write));
                if (in_acc) chk("rnd_sram_addr", bus.sram_addr, rsp_addr);
                if_done  = e_if;
                mem_done = e_mem;
            end
        end
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, fixed-latency unified SRAM between the instruction-fetch stage and the MEM stage of the 5-stage ARM pipeline.
- Accepts level-held requests from each side.
- Grants one request at a time and sequences the SRAM through a wait-state FSM.
- Returns a one-cycle ready pulse with read data.
- Drives the pipeline-wide freeze while a data access is outstanding.

Parameters:
ADDR_W, 32, address width of both requesters and the SRAM
DATA_W, 32, data width
WAIT_CYCLES, 2, SRAM access cycles per transfer; legal range 1..15

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_ready
if_addr  in  ADDR_W  fetch address
if_ready  out  1  one-cycle pulse; if_rdata valid this cycle
if_rdata  out  DATA_W  fetched instruction
mem_r_en  in  1  MEM-stage load request; held until mem_ready
mem_w_en  in  1  MEM-stage store request; held until mem_ready
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_ready  out  1  one-cycle pulse; load data valid or store committed
mem_rdata  out  DATA_W  load data
freeze  out  1  pipeline stall: (mem_r_en|mem_w_en) & ~mem_ready, combinational
sram_addr  out  ADDR_W  registered SRAM address
sram_wdata  out  DATA_W  registered SRAM write data
sram_we  out  1  SRAM write strobe
sram_oe  out  1  SRAM output enable
sram_rdata  in  DATA_W  SRAM read data, valid in last ACCESS cycle

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset: state=IDLE; cnt=0; grant=none.
  - if_ready=0, mem_ready=0, sram_we=0, sram_oe=0.
  - sram_addr, sram_wdata, if_rdata and mem_rdata = 0.
  - Reset mid-access aborts the transfer at the next edge: no ready pulse, and sram_we drops the same edge.
- IDLE, arbitration:
  - If any request is pending, latch grant, address and wdata; cnt<=WAIT_CYCLES-1; go to ACCESS.
  - Priority is data port over fetch, because the MEM instruction is older.
  - mem_r_en and mem_w_en both high is treated as a write.
- ACCESS:
  - sram_we = granted write; sram_oe = granted read. Both held for every ACCESS cycle.
  - Decrement cnt each cycle.
  - When cnt==0: capture sram_rdata into the granted port's rdata register (reads only), go to RESP.
- RESP:
  - The granted port's ready=1 for exactly one cycle; sram_we=sram_oe=0.
  - Always returns to IDLE; never re-arbitrates in RESP, because the requester still holds req during its ready cycle.
- Latency: request first seen in IDLE at cycle n → ready at cycle n+WAIT_CYCLES+1. Next grant no earlier than n+WAIT_CYCLES+2.
- rdata registers hold their value until overwritten by the next read on the same port. Stores leave mem_rdata unchanged.
- A request that drops while granted still completes. Its ready pulse is issued and no retry occurs.
- sram_addr and sram_wdata hold their last value outside ACCESS.
- Only one grant is outstanding at a time. if_ready and mem_ready are never high together.

Optional Feature:
ARB_RR_EN
- Defined: one-bit last_grant register (reset: fetch). When both ports are pending in IDLE, grant the port not granted last. A single pending port is always granted.
- Undefined: fixed data-over-fetch priority as above; last_grant is not implemented.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, freeze=0; rst asserted mid-ACCESS → next cycle IDLE, sram_we=0, no ready pulse.
- WAIT_CYCLES=2, SRAM returns 0xE3A01005 for 0x40; if_req=1, if_addr=0x40 at cycle 0 → sram_oe=1 cycles 1–2, if_ready=1 and if_rdata=0xE3A01005 at cycle 3.
- Store mem_w_en=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, then load 0x100 → sram_we high 2 cycles; freeze=1 until mem_ready; load returns 0xDEADBEEF with mem_ready 3 cycles after its grant.
- if_req and mem_r_en both asserted at cycle 0 (fixed priority) → mem_ready cycle 3, IDLE cycle 4, if_ready cycle 7.
- ARB_RR_EN: mem_r_en held high across back-to-back loads with if_req held → grants alternate fetch/mem; fetch is never starved for more than one data transfer.
- WAIT_CYCLES=1 boundary: single read → ready at cycle 2; if_req dropped during ACCESS still yields if_ready.
